// File: rtl/lvds_align_pkg.sv
// Shared definitions for the LVDS word-alignment trainer.
// Optional relock behaviour is selected with LVDS_WORD_ALIGN_RELOCK_EN.
package lvds_align_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned MATCH_W   = 4;
  localparam int unsigned SLIP_W    = 3;
  localparam int unsigned SETTLE_W  = 4;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned POP_W     = 4;

  // Per-lane alignment states
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SLIP   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOCKED = 3'd4;
  localparam logic [STATE_W-1:0] ST_FAIL   = 3'd5;

  // Number of set bits across the lane vector
  function automatic logic [POP_W-1:0] lane_popcount(input logic [NUM_LANES-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lvds_lane_align.sv
// Per-lane word-alignment FSM: compares against the training word,
// issues bitslip pulses and waits for the ISERDES to settle.
// LVDS_WORD_ALIGN_RELOCK_EN lets a locked lane fall back to CHECK on a mismatch.
module lvds_lane_align
  import lvds_align_pkg::*;
#(
  parameter logic [LANE_W-1:0] TRAIN_PATTERN = 8'h39,
  parameter int unsigned       MATCH_COUNT   = 4,
  parameter int unsigned       SETTLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LANE_W-1:0] lane_data_i,
  input  logic              train_en_i,
  input  logic              rise_i,
  output logic              bitslip_o,
  output logic              aligned_o,
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
  output logic              relock_c_o,
`endif
  output logic              failed_o
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [SLIP_W-1:0]   slip_q, slip_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                bitslip_q, aligned_q, failed_q;
  logic                hit_c;
  logic [MATCH_W-1:0]  match_inc_c;

  assign hit_c       = (lane_data_i == TRAIN_PATTERN);
  assign match_inc_c = match_q + MATCH_W'(1);

  // Next-state and counter update; rise has priority over every state
  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    slip_d   = slip_q;
    settle_d = settle_q;
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
    relock_c_o = 1'b0;
`endif
    if (rise_i) begin
      state_d  = ST_CHECK;
      match_d  = '0;
      slip_d   = '0;
      settle_d = '0;
    end else begin
      case (state_q)
        ST_CHECK: begin
          if (!train_en_i) begin
            state_d  = ST_IDLE;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
          end else if (hit_c) begin
            match_d = match_inc_c;
            if (match_inc_c == MATCH_W'(MATCH_COUNT)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_d = '0;
            if (slip_q == '1) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          if (!train_en_i) begin
            state_d  = ST_IDLE;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
          end else begin
            slip_d   = slip_q + SLIP_W'(1);
            settle_d = SETTLE_W'(SETTLE_CYCLES);
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!train_en_i) begin
            state_d  = ST_IDLE;
            match_d  = '0;
            slip_d   = '0;
            settle_d = '0;
          end else begin
            settle_d = settle_q - SETTLE_W'(1);
            if (settle_q <= SETTLE_W'(1)) begin
              state_d = ST_CHECK;
            end
          end
        end
        ST_LOCKED: begin
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
          if (train_en_i && !hit_c) begin
            state_d    = ST_CHECK;
            match_d    = '0;
            relock_c_o = 1'b1;
          end
`endif
        end
        ST_IDLE, ST_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      match_q   <= '0;
      slip_q    <= '0;
      settle_q  <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      slip_q    <= slip_d;
      settle_q  <= settle_d;
      bitslip_q <= (state_d == ST_SLIP);
      aligned_q <= (state_d == ST_LOCKED);
      failed_q  <= (state_d == ST_FAIL);
    end
  end

  assign bitslip_o = bitslip_q;
  assign aligned_o = aligned_q;
  assign failed_o  = failed_q;

endmodule

// File: rtl/lvds_word_align.sv
// Word-alignment trainer for the 8-lane LVDS sensor receive path.
// Holds training-enable edge detect, the lane data register, status
// reduction and (with LVDS_WORD_ALIGN_RELOCK_EN) the relock event counter.
module lvds_word_align
  import lvds_align_pkg::*;
#(
  parameter logic [LANE_W-1:0] TRAIN_PATTERN = 8'h39,
  parameter int unsigned       MATCH_COUNT   = 4,
  parameter int unsigned       SETTLE_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES*LANE_W-1:0] i_lane_data,
  input  logic                        i_train_en,
  output logic [NUM_LANES-1:0]        o_bitslip,
  output logic [NUM_LANES-1:0]        o_aligned,
  output logic [NUM_LANES-1:0]        o_failed,
  output logic                        o_done,
  output logic                        o_all_aligned,
  output logic [NUM_LANES*LANE_W-1:0] o_lane_data,
  output logic [CNT_W-1:0]            o_relock_count
);

  logic                        train_q;
  logic                        rise_c;
  logic [NUM_LANES*LANE_W-1:0] data_q;
  logic [NUM_LANES-1:0]        bitslip_w, aligned_w, failed_w;
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
  logic [NUM_LANES-1:0]        relock_c;
`endif

  assign rise_c = i_train_en & ~train_q;

  // Enable edge register and unconditional data pipeline stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      train_q <= 1'b0;
      data_q  <= '0;
    end else begin
      train_q <= i_train_en;
      data_q  <= i_lane_data;
    end
  end

  // One independent aligner per lane
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    lvds_lane_align #(
      .TRAIN_PATTERN (TRAIN_PATTERN),
      .MATCH_COUNT   (MATCH_COUNT),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .lane_data_i (i_lane_data[n*LANE_W +: LANE_W]),
      .train_en_i  (i_train_en),
      .rise_i      (rise_c),
      .bitslip_o   (bitslip_w[n]),
      .aligned_o   (aligned_w[n]),
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
      .relock_c_o  (relock_c[n]),
`endif
      .failed_o    (failed_w[n])
    );
  end

`ifdef LVDS_WORD_ALIGN_RELOCK_EN
  logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;
  logic [CNT_W:0]   relock_sum_c;

  // Saturating sum of relock events across lanes
  always_comb begin
    relock_sum_c = (CNT_W+1)'(relock_cnt_q) + (CNT_W+1)'(lane_popcount(relock_c));
    relock_cnt_d = relock_sum_c[CNT_W] ? '1 : relock_sum_c[CNT_W-1:0];
  end

  // Relock counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relock_cnt_q <= '0;
    end else begin
      relock_cnt_q <= relock_cnt_d;
    end
  end

  assign o_relock_count = relock_cnt_q;
`else
  assign o_relock_count = '0;
`endif

  assign o_bitslip     = bitslip_w;
  assign o_aligned     = aligned_w;
  assign o_failed      = failed_w;
  assign o_done        = &(aligned_w | failed_w);
  assign o_all_aligned = &aligned_w;
  assign o_lane_data   = data_q;

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align; lane data follows a simple ISERDES
// model where each bitslip pulse rotates that lane's byte left by one bit.
module tb_lvds_word_align;

  logic        clk;
  logic        rst;
  logic [63:0] i_lane_data;
  logic        i_train_en;
  logic [7:0]  o_bitslip, o_aligned, o_failed, o_relock_count;
  logic        o_done, o_all_aligned;
  logic [63:0] o_lane_data;

  int          n_checks;
  int          n_fail;
  int          cyc;
  logic [7:0]  base [8];
  int          rot  [8];

  lvds_word_align #(
    .TRAIN_PATTERN (8'h39),
    .MATCH_COUNT   (4),
    .SETTLE_CYCLES (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_lane_data    (i_lane_data),
    .i_train_en     (i_train_en),
    .o_bitslip      (o_bitslip),
    .o_aligned      (o_aligned),
    .o_failed       (o_failed),
    .o_done         (o_done),
    .o_all_aligned  (o_all_aligned),
    .o_lane_data    (o_lane_data),
    .o_relock_count (o_relock_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rotr8(input logic [7:0] v, input int r);
    logic [7:0] x;
    x = v;
    for (int k = 0; k < r; k++) x = {x[0], x[7:1]};
    return x;
  endfunction

  task automatic drive_data();
    for (int n = 0; n < 8; n++) i_lane_data[n*8 +: 8] = rotr8(base[n], rot[n]);
  endtask

  // Advance one cycle, sample 1 time unit after the edge, apply slips
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < 8; n++) if (o_bitslip[n]) rot[n] = (rot[n] + 7) % 8;
    drive_data();
  endtask

  task automatic set_lanes(input logic [7:0] v);
    for (int n = 0; n < 8; n++) begin
      base[n] = v;
      rot[n]  = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_train_en = 1'b0;
    drive_data();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    step();
  endtask

  task automatic start_train();
    i_train_en = 1'b1;
    cyc = 0;
    drive_data();
  endtask

  task automatic test_reset();
    logic bad;
    set_lanes(8'h39);
    base[3] = 8'h00;
    do_reset();
    start_train();
    step();
    step();
    n_checks++;
    if (o_bitslip !== 8'h08) begin
      n_fail++;
      $display("FAIL reset_pre_slip: bitslip=%h expected 08", o_bitslip);
    end
    step();
    step();
    rst = 1'b1;
    i_train_en = 1'b0;
    #1;
    n_checks++;
    if ({o_bitslip, o_aligned, o_failed, o_done, o_all_aligned, o_relock_count} !== 34'd0 ||
        o_lane_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: bs=%h al=%h fl=%h dn=%b aa=%b rc=%h data=%h expected all 0",
               o_bitslip, o_aligned, o_failed, o_done, o_all_aligned, o_relock_count, o_lane_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      step();
      if (o_bitslip !== 8'h00 || o_aligned !== 8'h00 || o_failed !== 8'h00) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: activity=%b expected 0", bad);
    end
  endtask

  task automatic test_data_pipe();
    logic [63:0] prev;
    for (int k = 0; k < 4; k++) begin
      prev = {$urandom, $urandom};
      i_lane_data = prev;
      @(posedge clk);
      #1;
      n_checks++;
      if (o_lane_data !== prev) begin
        n_fail++;
        $display("FAIL data_pipe[%0d]: got %h expected %h", k, o_lane_data, prev);
      end
    end
  endtask

  task automatic test_all_aligned();
    logic [7:0] seen;
    set_lanes(8'h39);
    do_reset();
    start_train();
    seen = 8'h00;
    for (int c = 1; c <= 5; c++) begin
      step();
      seen |= o_bitslip;
      if (cyc == 4) begin
        n_checks++;
        if (o_aligned !== 8'h00) begin
          n_fail++;
          $display("FAIL all_aligned_early: aligned=%h expected 00 at cycle 4", o_aligned);
        end
      end
    end
    n_checks++;
    if (o_aligned !== 8'hFF || o_all_aligned !== 1'b1 || o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL all_aligned_lock: aligned=%h all=%b done=%b expected FF 1 1",
               o_aligned, o_all_aligned, o_done);
    end
    n_checks++;
    if (seen !== 8'h00) begin
      n_fail++;
      $display("FAIL all_aligned_noslip: bitslip seen=%h expected 00", seen);
    end
  endtask

  task automatic test_slip_lane2();
    int pulses;
    int pc [3];
    int lock_cyc;
    logic [7:0] al5;
    logic other;
    set_lanes(8'h39);
    rot[2] = 3;
    do_reset();
    start_train();
    pulses = 0;
    lock_cyc = -1;
    other = 1'b0;
    al5 = 8'h00;
    for (int k = 0; k < 3; k++) pc[k] = -1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (o_bitslip[2]) begin
        if (pulses < 3) pc[pulses] = cyc;
        pulses++;
      end
      if ((o_bitslip & 8'hFB) != 8'h00) other = 1'b1;
      if (cyc == 5) al5 = o_aligned;
      if (o_aligned[2] && lock_cyc < 0) lock_cyc = cyc;
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL slip2_count: pulses=%0d expected 3", pulses);
    end
    n_checks++;
    if (pc[0] != 2 || pc[1] != 7 || pc[2] != 12) begin
      n_fail++;
      $display("FAIL slip2_spacing: pulses at %0d,%0d,%0d expected 2,7,12", pc[0], pc[1], pc[2]);
    end
    n_checks++;
    if (al5 !== 8'hFB) begin
      n_fail++;
      $display("FAIL slip2_others: aligned at cycle 5=%h expected FB", al5);
    end
    n_checks++;
    if (lock_cyc != 20) begin
      n_fail++;
      $display("FAIL slip2_lock: lane 2 locked at cycle %0d expected 20", lock_cyc);
    end
    n_checks++;
    if (o_done !== 1'b1 || o_all_aligned !== 1'b1 || other !== 1'b0) begin
      n_fail++;
      $display("FAIL slip2_done: done=%b all=%b other_slip=%b expected 1 1 0",
               o_done, o_all_aligned, other);
    end
  endtask

  task automatic test_fail_lane5();
    int pulses;
    logic done36;
    set_lanes(8'h39);
    base[5] = 8'h00;
    do_reset();
    start_train();
    pulses = 0;
    done36 = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      step();
      if (o_bitslip[5]) pulses++;
      if (cyc == 36) done36 = o_done;
    end
    n_checks++;
    if (pulses != 7) begin
      n_fail++;
      $display("FAIL fail5_slips: pulses=%0d expected 7", pulses);
    end
    n_checks++;
    if (done36 !== 1'b0) begin
      n_fail++;
      $display("FAIL fail5_done_early: done at cycle 36=%b expected 0", done36);
    end
    n_checks++;
    if (o_failed !== 8'h20 || o_aligned !== 8'hDF) begin
      n_fail++;
      $display("FAIL fail5_status: failed=%h aligned=%h expected 20 DF", o_failed, o_aligned);
    end
    n_checks++;
    if (o_done !== 1'b1 || o_all_aligned !== 1'b0) begin
      n_fail++;
      $display("FAIL fail5_done: done=%b all=%b expected 1 0", o_done, o_all_aligned);
    end
  endtask

  task automatic test_retrain_mid_slip();
    int pulses;
    logic [7:0] al5;
    set_lanes(8'h39);
    base[1] = 8'h00;
    do_reset();
    start_train();
    step();
    step();
    n_checks++;
    if (o_bitslip !== 8'h02) begin
      n_fail++;
      $display("FAIL retrain_in_slip: bitslip=%h expected 02", o_bitslip);
    end
    i_train_en = 1'b0;
    step();
    n_checks++;
    if (o_bitslip !== 8'h00) begin
      n_fail++;
      $display("FAIL retrain_abort: bitslip=%h expected 00", o_bitslip);
    end
    start_train();
    pulses = 0;
    al5 = 8'h00;
    for (int c = 1; c <= 37; c++) begin
      step();
      if (o_bitslip[1]) pulses++;
      if (cyc == 5) al5 = o_aligned;
    end
    n_checks++;
    if (pulses != 7 || o_failed !== 8'h02) begin
      n_fail++;
      $display("FAIL retrain_counters: pulses=%0d failed=%h expected 7 02", pulses, o_failed);
    end
    n_checks++;
    if (al5 !== 8'hFD) begin
      n_fail++;
      $display("FAIL retrain_relock: aligned at cycle 5=%h expected FD", al5);
    end
  endtask

  task automatic test_relock();
    logic [7:0] exp_drop;
    logic [7:0] exp_cnt;
`ifdef LVDS_WORD_ALIGN_RELOCK_EN
    exp_drop = 8'hFE;
    exp_cnt  = 8'd1;
`else
    exp_drop = 8'hFF;
    exp_cnt  = 8'd0;
`endif
    set_lanes(8'h39);
    do_reset();
    start_train();
    repeat (5) step();
    n_checks++;
    if (o_aligned !== 8'hFF) begin
      n_fail++;
      $display("FAIL relock_pre: aligned=%h expected FF", o_aligned);
    end
    base[0] = 8'hFF;
    drive_data();
    base[0] = 8'h39;
    step();
    n_checks++;
    if (o_aligned !== 8'h00 + exp_drop || o_relock_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL relock_drop: aligned=%h count=%0d expected %h %0d",
               o_aligned, o_relock_count, exp_drop, exp_cnt);
    end
    repeat (3) step();
    n_checks++;
    if (o_aligned !== exp_drop) begin
      n_fail++;
      $display("FAIL relock_wait: aligned at cycle 9=%h expected %h", o_aligned, exp_drop);
    end
    step();
    n_checks++;
    if (o_aligned !== 8'hFF || o_relock_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL relock_done: aligned=%h count=%0d expected FF %0d",
               o_aligned, o_relock_count, exp_cnt);
    end
  endtask

  initial begin
    rst         = 1'b1;
    i_train_en  = 1'b0;
    i_lane_data = 64'd0;
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    set_lanes(8'h39);
    test_reset();
    test_data_pipe();
    test_all_aligned();
    test_slip_lane2();
    test_fail_lane5();
    test_retrain_mid_slip();
    test_relock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lvds_word_align.md
Name: lvds_word_align

Overview:
- Word-alignment trainer that sits directly downstream of the 8-lane LVDS descramble stage in the Sony IMX sensor receive path.
- Takes the eight per-lane de-interleaved, polarity-corrected bytes and searches each lane for the sensor training word.
- Drives per-lane bitslip pulses back to the ISERDES until every lane is word-aligned (or has failed).
- Passes aligned lane data through, registered, to the sync-code decoder.

Parameters:
- TRAIN_PATTERN, 8'h39, training word the sensor transmits on every lane during training.
- MATCH_COUNT, 4, consecutive matching cycles required to declare a lane locked (1..15).
- SETTLE_CYCLES, 3, idle cycles after each bitslip pulse before comparing again (1..15).

Ports:
- clk  in  1  receive-word clock (ISERDES CLKDIV domain).
- rst  in  1  asynchronous, active-high reset.
- i_lane_data  in  64  lane n byte at [8n+7:8n]; fed from the descramble outputs lvds0..lvds7.
- i_train_en  in  1  level: training enable; rising edge (re)starts alignment.
- o_bitslip  out  8  one-cycle bitslip pulse per lane, bit n to ISERDES n.
- o_aligned  out  8  lane n is in LOCKED.
- o_failed  out  8  lane n is in FAIL.
- o_done  out  1  every lane is LOCKED or FAIL.
- o_all_aligned  out  1  o_aligned == 8'hFF.
- o_lane_data  out  64  i_lane_data registered one cycle, unconditionally.
- o_relock_count  out  8  total relock events, saturating (optional feature only; otherwise tied to 0).

Behaviour:
- Reset (async, active-high): every lane enters IDLE; all outputs are 0, including o_lane_data; the i_train_en edge register is cleared.
- i_train_en is sampled into a one-cycle-delayed copy; rise = i_train_en & ~delayed.
- Each lane runs an identical independent FSM with states IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL. Per lane it keeps a match counter (4b), slip counter (3b) and settle counter (4b).
- Rise (any state, including mid-SLIP/SETTLE): the lane goes to CHECK with all counters cleared. o_bitslip is 0 in the cycle following rise.
- IDLE: hold; wait for rise.
- CHECK:
  - Byte == TRAIN_PATTERN: increment the match counter. When the incremented value equals MATCH_COUNT, go to LOCKED.
  - Mismatch: clear the match counter. If the slip counter is 7 (all 8 phases tried), go to FAIL; otherwise go to SLIP.
- SLIP: assert o_bitslip[n] for exactly this one cycle, increment the slip counter, load the settle counter, go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles with no compare, then go to CHECK.
- LOCKED and FAIL: hold until the next rise.
- i_train_en low while in CHECK/SLIP/SETTLE: abort to IDLE and clear counters. LOCKED and FAIL are unaffected by i_train_en low.
- Latency: with correct data on a lane, o_aligned[n] rises exactly MATCH_COUNT+1 cycles after the cycle in which rise is sampled.
- Status outputs are registered:
  - o_aligned/o_failed reflect the lane state.
  - o_done/o_all_aligned are combinational from those registers (no extra cycle).
- Never-lock bound per lane: 8 compare windows and 7 slips, then FAIL.

Optional Feature:
- Macro LVDS_WORD_ALIGN_RELOCK_EN.
- Defined: a lane in LOCKED that sees a mismatch while i_train_en is high returns to CHECK with the match counter cleared and the slip counter kept. o_relock_count increments once per such event (summed across lanes, saturating at 255). If several lanes relock in the same cycle, the count adds the number of lanes.
- Undefined: LOCKED is sticky until the next rise; o_relock_count is constant 0.

Decomposition:
- Shared package lvds_align_pkg: lane-state enum (IDLE..FAIL), NUM_LANES=8, LANE_W=8, counter widths.
- One natural sub-module: lvds_lane_align, the per-lane FSM with counters. It is instantiated 8 times by generate.
- The top level holds edge detect, data register, status reduction and the relock counter.

Test Plan:
- Reset mid-SETTLE on lane 3: outputs 0 immediately, lanes IDLE; after release, no bitslip until a new rise.
- All lanes 8'h39, rise at cycle 0 → o_aligned 8'hFF and o_all_aligned high at cycle 5, o_bitslip never pulses.
- Lane 2 rotated by 3 bits (8'h27), others 8'h39; the stimulus model applies each bitslip → exactly 3 pulses on o_bitslip[2], each followed by 3 SETTLE cycles; lane 2 locks last; o_done high.
- Lane 5 constant 8'h00 → 7 bitslip pulses, then o_failed[5]=1, o_done=1, o_all_aligned=0.
- i_train_en re-pulsed while lane 1 is in SLIP → o_bitslip[1]=0 next cycle, lane 1 counters cleared, retraining completes.
- RELOCK_EN: locked lane 0 receives one 8'hFF byte with i_train_en high → o_aligned[0] drops next cycle, o_relock_count=1, relocks after 4 matches; without the macro, o_aligned[0] stays 1.
